// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue sequencer: MIPS funct codes, ALU control codes, FSM states.
// Optional feature macro: FUNC_ERR_EN (unknown-funct error reporting in alu_issue_seq).
package alu_issue_pkg;

  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_NOR = 6'd39;
  localparam logic [5:0] FUNCT_SLT = 6'd42;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_BAD = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational MIPS R-type funct to ALU control mapping; unrecognised funct yields ALU_BAD.
module alu_func_decode
  import alu_issue_pkg::*;
(
  input  logic [5:0] func,
  output logic [3:0] ctl
);

  always_comb begin
    ctl = ALU_BAD;
    case (func)
      FUNCT_ADD: ctl = ALU_ADD;
      FUNCT_SUB: ctl = ALU_SUB;
      FUNCT_AND: ctl = ALU_AND;
      FUNCT_OR:  ctl = ALU_OR;
      FUNCT_NOR: ctl = ALU_NOR;
      FUNCT_SLT: ctl = ALU_SLT;
      default:   ctl = ALU_BAD;
    endcase
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer: accepts one R-type op, drives an external ALU, returns the result on a handshake.
// Optional feature macro: FUNC_ERR_EN adds out_err and zeroes results of unknown funct codes.
module alu_issue_seq
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_func,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic [15:0] op_count,
`ifdef FUNC_ERR_EN
  output logic        out_err,
`endif
  output state_e      state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and in_ready may depend on out_ready (DONE pass-through).

  state_e      state;
  state_e      state_next;
  logic        accept;
  logic [3:0]  dec_ctl;
  logic [15:0] op_count_q;

  alu_func_decode u_decode (
    .func (in_func),
    .ctl  (dec_ctl)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        accept    = in_valid && out_ready;
        if (out_ready) state_next = in_valid ? ST_EXEC : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

`ifdef FUNC_ERR_EN
  logic err_q;
  logic bad_op;

  assign bad_op  = (alu_ctl == ALU_BAD);
  assign out_err = err_q && (state == ST_DONE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ctl    <= 4'd0;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      out_result <= 32'd0;
      out_zero   <= 1'b0;
      op_count_q <= 16'd0;
`ifdef FUNC_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      if (accept) begin
        alu_ctl <= dec_ctl;
        alu_a   <= in_a;
        alu_b   <= in_b;
      end
      // The ALU settles during EXEC because its inputs were registered at acceptance.
      if (state == ST_EXEC) begin
`ifdef FUNC_ERR_EN
        out_result <= bad_op ? 32'd0 : alu_out;
        out_zero   <= bad_op ? 1'b0 : alu_zero;
        err_q      <= bad_op;
`else
        out_result <= alu_out;
        out_zero   <= alu_zero;
`endif
      end
      if (out_valid && out_ready) op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count  = op_count_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed plus randomized bench for alu_issue_seq, with a behavioural ALU and a result scoreboard.
// Build with FUNC_ERR_EN defined to exercise the out_err variant.
module tb_alu_issue_seq;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_func;
  logic [31:0] in_a, in_b;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [15:0] op_count;
  logic        err_w;
  state_e      state_dbg;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];   // {err, zero, result} per accepted op
  logic [15:0] exp_count;

  always #5 clk = ~clk;

  alu_issue_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_func    (in_func),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_ctl    (alu_ctl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .op_count   (op_count),
`ifdef FUNC_ERR_EN
    .out_err    (err_w),
`endif
    .state_dbg  (state_dbg)
  );

`ifndef FUNC_ERR_EN
  assign err_w = 1'b0;
`endif

  // Behavioural MIPS ALU driven by the sequencer outputs.
  function automatic logic [31:0] alu_model(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out  = alu_model(alu_ctl, alu_a, alu_b);
  assign alu_zero = (alu_out == 32'd0);

  function automatic logic [3:0] ref_ctl(logic [5:0] f);
    case (f)
      6'd32: return 4'd2;
      6'd34: return 4'd6;
      6'd36: return 4'd0;
      6'd37: return 4'd1;
      6'd39: return 4'd12;
      6'd42: return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  // Expected captured value straight from the funct semantics.
  function automatic logic [33:0] ref_pack(logic [5:0] f, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    logic        known;
    known = 1'b1;
    case (f)
      6'd32: r = a + b;
      6'd34: r = a - b;
      6'd36: r = a & b;
      6'd37: r = a | b;
      6'd39: r = ~(a | b);
      6'd42: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; known = 1'b0; end
    endcase
`ifdef FUNC_ERR_EN
    if (!known) return {1'b1, 1'b0, 32'd0};
`endif
    return {1'b0, (r == 32'd0), r};
  endfunction

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] result_bus();
    return {err_w, out_zero, out_result};
  endfunction

  // Starts at a negedge with the DUT able to accept; ends at the negedge inside EXEC.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bit accepted = 0;
    in_valid = 1'b1;
    in_func  = f;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) begin
        @(posedge clk);
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) check("accept_timeout", 34'd0, 34'd1);
    exp_q.push_back(ref_pack(f, a, b));
    @(negedge clk);
    in_valid = 1'b0;
    in_func  = 6'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    check("exec_alu_ctl", 34'(alu_ctl), 34'(ref_ctl(f)));
    check("exec_alu_a", 34'(alu_a), 34'(a));
    check("exec_alu_b", 34'(alu_b), 34'(b));
    check("exec_out_valid", 34'(out_valid), 34'd0);
    check("exec_in_ready", 34'(in_ready), 34'd0);
  endtask

  // From the negedge in EXEC: result appears next cycle, held for 'stall' cycles, then taken.
  task automatic finish_op(input int stall);
    logic [33:0] exp;
    logic [3:0]  ctl_hold;
    logic [31:0] a_hold;
    ctl_hold  = alu_ctl;
    a_hold    = alu_a;
    out_ready = (stall == 0);
    @(negedge clk);
    exp = exp_q[0];
    check("done_out_valid", 34'(out_valid), 34'd1);
    check("done_result", result_bus(), exp);
    for (int s = 1; s <= stall; s++) begin
      in_valid = (s != stall);
      in_func  = 6'($urandom);
      in_a     = $urandom;
      @(negedge clk);
      check("stall_out_valid", 34'(out_valid), 34'd1);
      check("stall_result", result_bus(), exp);
      check("stall_in_ready", 34'(in_ready), 34'd0);
      check("stall_op_count", 34'(op_count), 34'(exp_count));
      check("stall_alu_hold", {2'b0, ctl_hold, a_hold[27:0]}, {2'b0, alu_ctl, alu_a[27:0]});
      if (s == stall) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    void'(exp_q.pop_front());
    exp_count++;
    check("xfer_op_count", 34'(op_count), 34'(exp_count));
    check("xfer_out_valid", 34'(out_valid), 34'd0);
    check("xfer_in_ready", 34'(in_ready), 34'd1);
  endtask

  // Second op presented while the first is executing; accepted in the first op's DONE cycle.
  task automatic back_to_back(input logic [5:0] f1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic [5:0] f2, input logic [31:0] a2, input logic [31:0] b2);
    issue(f1, a1, b1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_func   = f2;
    in_a      = a2;
    in_b      = b2;
    @(negedge clk);
    check("b2b_first_valid", 34'(out_valid), 34'd1);
    check("b2b_first_result", result_bus(), exp_q[0]);
    check("b2b_done_in_ready", 34'(in_ready), 34'd1);
    @(negedge clk);
    void'(exp_q.pop_front());
    exp_count++;
    exp_q.push_back(ref_pack(f2, a2, b2));
    in_valid = 1'b0;
    check("b2b_op_count", 34'(op_count), 34'(exp_count));
    check("b2b_gap_valid", 34'(out_valid), 34'd0);
    check("b2b_second_ctl", 34'(alu_ctl), 34'(ref_ctl(f2)));
    check("b2b_second_a", 34'(alu_a), 34'(a2));
    finish_op(0);
  endtask

  function automatic logic [5:0] pick_func();
    logic [5:0] tbl [7];
    tbl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0};
    tbl[6] = 6'($urandom);
    return tbl[$urandom_range(0, 6)];
  endfunction

  function automatic logic [31:0] pick_operand();
    return ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_func = 6'd0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b0;
    exp_count = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 34'(in_ready), 34'd1);
    check("rst_out_valid", 34'(out_valid), 34'd0);
    check("rst_alu_regs", {alu_ctl, alu_a[29:0]}, 34'd0);
    check("rst_alu_b", 34'(alu_b), 34'd0);
    check("rst_result", result_bus(), 34'd0);
    check("rst_op_count", 34'(op_count), 34'd0);
    rst = 1'b0;
    @(negedge clk);

    // add 5+7, out_valid two cycles after the accept cycle
    issue(6'd32, 32'd5, 32'd7);
    finish_op(0);
    check("add_count_is_1", 34'(op_count), 34'd1);

    // sub of equal operands gives zero
    issue(6'd34, 32'h1234, 32'h1234);
    check("sub_ctl_6", 34'(alu_ctl), 34'd6);
    finish_op(0);

    // slt 3<9 held under backpressure for 4 cycles
    issue(6'd42, 32'd3, 32'd9);
    finish_op(4);

    back_to_back(6'd32, 32'd100, 32'd23, 6'd36, 32'hF0F0_FFFF, 32'h0FF0_1234);
    back_to_back(6'd39, 32'h0, 32'h0, 6'd42, 32'hFFFF_FFFF, 32'd1);

    // unknown funct
    issue(6'h3F, 32'hDEAD_BEEF, 32'h1);
    check("bad_ctl_15", 34'(alu_ctl), 34'd15);
    finish_op(1);

    // reset while in EXEC drops the op
    issue(6'd37, 32'h55, 32'hAA);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_count = 16'd0;
    check("rst_exec_out_valid", 34'(out_valid), 34'd0);
    check("rst_exec_op_count", 34'(op_count), 34'd0);
    check("rst_exec_alu_ctl", 34'(alu_ctl), 34'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 34'(in_ready), 34'd1);
    check("post_rst_out_valid", 34'(out_valid), 34'd0);

    // counter wrap from 0xFFFF
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    exp_count = 16'hFFFF;
    @(negedge clk);
    check("preload_count", 34'(op_count), 34'(exp_count));
    issue(6'd32, 32'd1, 32'd1);
    finish_op(0);
    check("wrap_count_zero", 34'(op_count), 34'd0);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        back_to_back(pick_func(), pick_operand(), pick_operand(),
                     pick_func(), pick_operand(), pick_operand());
      end else begin
        issue(pick_func(), pick_operand(), pick_operand());
        finish_op($urandom_range(0, 3));
      end
    end
    check("scoreboard_empty", 34'(exp_q.size()), 34'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
